// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two requester ports, the response port and the
// link to the shared ALU. The arbiter uses the slave modport. The master modport
// is for whatever drives the requests and models the ALU.
interface alu_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [3:0]        req0_ctrl;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [3:0]        req1_ctrl;

   logic              resp_valid;
   logic              resp_ready;
   logic              resp_id;
   logic [DATA_W-1:0] resp_result;
   logic              resp_zero;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [3:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctrl,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_ctrl,
      input  req1_ready,
      input  resp_valid, resp_id, resp_result, resp_zero,
      output resp_ready,
      input  alu_a, alu_b, alu_ctrl,
      output alu_result, alu_zero
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctrl,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_ctrl,
      output req1_ready,
      output resp_valid, resp_id, resp_result, resp_zero,
      input  resp_ready,
      output alu_a, alu_b, alu_ctrl,
      input  alu_result, alu_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// The block runs one operation at a time through IDLE -> EXEC -> RESP.
// Arbitration is round-robin by default.
// Defining ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority and removes
// the last-grant pointer.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [3:0]        ctrl;
      logic              id;
   } op_t;

   state_t            state, state_nxt;
   op_t               op_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              gnt0, gnt1;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic              last_id;   // 1 = requester 1 was granted most recently

   // last-grant pointer moves only on acceptance; reset value favours requester 0
   always_ff @(posedge clk) begin
      if (!rst_n)           last_id <= 1'b1;
      else if (gnt0 | gnt1) last_id <= gnt1;
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // grant decision and next state; a grant is offered only in IDLE and never in reset
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      state_nxt = state;
      if (state == IDLE && rst_n) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         gnt0 = bus.req0_valid;
         gnt1 = bus.req1_valid & ~bus.req0_valid;
`else
         gnt0 = bus.req0_valid & (~bus.req1_valid | last_id);
         gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_id);
`endif
      end
      case (state)
         IDLE:    if (gnt0 | gnt1) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // capture the winner's operands; the ALU only ever sees this register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q <= '0;
      end else if (gnt1) begin
         op_q <= '{a: bus.req1_a, b: bus.req1_b, ctrl: bus.req1_ctrl, id: 1'b1};
      end else if (gnt0) begin
         op_q <= '{a: bus.req0_a, b: bus.req0_b, ctrl: bus.req0_ctrl, id: 1'b0};
      end
   end

   // sample the ALU output during EXEC; it is held through RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else if (state == EXEC) begin
         result_q <= bus.alu_result;
         zero_q   <= bus.alu_zero;
      end
   end

   assign bus.req0_ready  = gnt0;
   assign bus.req1_ready  = gnt1;
   assign bus.alu_a       = op_q.a;
   assign bus.alu_b       = op_q.b;
   assign bus.alu_ctrl    = op_q.ctrl;
   assign bus.resp_valid  = (state == RESP);
   assign bus.resp_id     = op_q.id;
   assign bus.resp_result = result_q;
   assign bus.resp_zero   = zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. A driver issues requests and pushes the expected
// responses into a queue. A monitor pops the queue and compares whenever the
// arbiter presents a response. The bench also models the shared ALU.
module tb_alu_arbiter;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_W(32)) bus();
   alu_arbiter #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0, failures = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        zero;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          grants[$];
   logic        pend[2];
   logic [31:0] ra[2], rb[2], rexp[2];
   logic [3:0]  rc[2];
   logic        rz[2];
   logic        outstanding = 1'b0;
   logic        last        = 1'b1;
   logic        rrdy        = 1'b1;

   // the shared ALU as a plain arithmetic function
   function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] c);
      logic [31:0] r;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0011: r = a ^ b;
         4'b0100: r = a << b[4:0];
         4'b0101: r = a >> b[4:0];
         4'b0110: r = a - b;
         4'b0111: r = {31'd0, $signed(a) < $signed(b)};
         4'b1100: r = ~(a | b);
         4'b1111: begin
            r = 32'd32;
            for (int i = 31; i >= 0; i--) if (a[i]) r = i;
         end
         default: r = a ^ ~b;
      endcase
      return r;
   endfunction

   always_comb begin
      bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);
      bus.alu_zero   = (alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl) == 32'd0);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // which requester the rules say should win, -1 for none
   function automatic int exp_grant(logic v0, logic v1, logic lst);
      if (!v0 && !v1) return -1;
      if (v0 && !v1)  return 0;
      if (v1 && !v0)  return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return lst ? 0 : 1;
`endif
   endfunction

   task automatic issue(int n, logic [31:0] a, logic [31:0] b, logic [3:0] c,
                        logic [31:0] er, logic ez);
      pend[n] = 1'b1; ra[n] = a; rb[n] = b; rc[n] = c; rexp[n] = er; rz[n] = ez;
   endtask

   task automatic issue_rand(int n);
      logic [31:0] a, b, r;
      logic [3:0]  c;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      c = 4'($urandom_range(0, 15));
      r = alu_fn(a, b, c);
      issue(n, a, b, c, r, r == 32'd0);
   endtask

   task automatic accept(int n);
      exp_t e;
      e.id = (n == 1); e.res = rexp[n]; e.zero = rz[n]; e.acc = cyc;
      q.push_back(e);
      grants.push_back(n);
      pend[n]     = 1'b0;
      outstanding = 1'b1;
      last        = (n == 1);
   endtask

   // one clock cycle: drive the inputs, check the ready outputs against the model
   // at negedge, and record acceptances and handshakes
   task automatic step();
      int g;
      bus.req0_valid = pend[0];
      bus.req0_a     = pend[0] ? ra[0] : $urandom;
      bus.req0_b     = pend[0] ? rb[0] : $urandom;
      bus.req0_ctrl  = pend[0] ? rc[0] : 4'($urandom_range(0, 15));
      bus.req1_valid = pend[1];
      bus.req1_a     = pend[1] ? ra[1] : $urandom;
      bus.req1_b     = pend[1] ? rb[1] : $urandom;
      bus.req1_ctrl  = pend[1] ? rc[1] : 4'($urandom_range(0, 15));
      bus.resp_ready = rrdy;
      @(negedge clk);
      if (!rst_n) begin
         chk("req0_ready_in_reset", bus.req0_ready, 0);
         chk("req1_ready_in_reset", bus.req1_ready, 0);
         q.delete(); grants.delete();
         outstanding = 1'b0;
         last        = 1'b1;
      end else begin
         g = outstanding ? -1 : exp_grant(pend[0], pend[1], last);
         chk("req0_ready", bus.req0_ready, g == 0);
         chk("req1_ready", bus.req1_ready, g == 1);
         if (outstanding && bus.resp_valid && bus.resp_ready) outstanding = 1'b0;
         else if (bus.req0_valid && bus.req0_ready)           accept(0);
         else if (bus.req1_valid && bus.req1_ready)           accept(1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 60; i++) begin
         if (!pend[0] && !pend[1] && !outstanding && q.size() == 0) break;
         step();
      end
      if (i == 60) begin
         checks++; failures++;
         $display("FAIL wait_idle: timeout, pending=%0d queue=%0d", outstanding, q.size());
      end
   endtask

   // monitor: compare every presented response with the head of the queue
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else if (q.size() == 0) begin
            chk("no_spurious_resp", bus.resp_valid, 0);
            prev = 1'b0;
         end else if (bus.resp_valid) begin
            e = q[0];
            if (!prev) chk("latency", cyc - e.acc, 2);
            chk("resp_id", bus.resp_id, e.id);
            chk("resp_result", bus.resp_result, e.res);
            chk("resp_zero", bus.resp_zero, e.zero);
            if (bus.resp_ready) begin
               void'(q.pop_front());
               prev = 1'b0;
            end else begin
               prev = 1'b1;
            end
         end else begin
            prev = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      // reset with both requesters asserting valid
      issue(0, 1, 2, 4'b0010, 3, 0);
      issue(1, 4, 5, 4'b0010, 9, 0);
      rst_n = 1'b0;
      step(); step();
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_id", bus.resp_id, 0);
      chk("rst_resp_result", bus.resp_result, 0);
      chk("rst_resp_zero", bus.resp_zero, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_ctrl", bus.alu_ctrl, 0);
      pend[0] = 1'b0; pend[1] = 1'b0;
      rst_n = 1'b1;

      // directed ALU operations
      issue(0, 5, 7, 4'b0010, 12, 0);          wait_idle();
      issue(1, 3, 3, 4'b0110, 0, 1);           wait_idle();
      issue(1, 32'h8, 0, 4'b1111, 3, 0);       wait_idle();

      // both requesters valid continuously from reset
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int i = 0; i < 40 && grants.size() < 4; i++) begin
         if (!pend[0]) issue_rand(0);
         if (!pend[1]) issue_rand(1);
         step();
      end
      if (grants.size() < 4) begin
         checks++; failures++;
         $display("FAIL grant_order: only %0d grants seen, required 4", grants.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("grant_order", grants[i], 0);
`else
            chk("grant_order", grants[i], i % 2);
`endif
         end
      end
      wait_idle();

      // consumer stalls for 4 cycles in RESP
      rrdy = 1'b0;
      issue_rand(0);
      for (int i = 0; i < 10 && !bus.resp_valid; i++) step();
      chk("stall_resp_valid", bus.resp_valid, 1);
      repeat (4) step();
      rrdy = 1'b1;
      wait_idle();

      // one reset cycle while in EXEC abandons the operation
      issue_rand(1);
      step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("abort_resp_valid", bus.resp_valid, 0);
      repeat (6) step();

      // resp_ready high in IDLE/EXEC, then low in RESP
      rrdy = 1'b1;
      issue_rand(0);
      step(); step();
      chk("early_ready_held", bus.resp_valid, 1);
      rrdy = 1'b0;
      repeat (3) step();
      rrdy = 1'b1;
      wait_idle();

      // random traffic with random back-pressure and an occasional reset
      for (int i = 0; i < 400; i++) begin
         if (!pend[0] && $urandom_range(0, 2) == 0) issue_rand(0);
         if (!pend[1] && $urandom_range(0, 2) == 0) issue_rand(1);
         rrdy  = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 149) != 0);
         step();
         rst_n = 1'b1;
      end
      rrdy = 1'b1;
      wait_idle();
      chk("final_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
